// File: rtl/icache_responder_pkg.sv
// icache_responder_pkg: shared geometry constants, FSM state and line types for the I-cache responder
package icache_responder_pkg;
    localparam int NUM_LINES       = 64;
    localparam int LINE_BITS       = 128;
    localparam int ADDR_W          = 32;
    localparam int ICACHE_OFF_BITS = $clog2(LINE_BITS / 8);
    localparam int ICACHE_IDX_BITS = $clog2(NUM_LINES);
    localparam int ICACHE_TAG_BITS = ADDR_W - ICACHE_OFF_BITS - ICACHE_IDX_BITS;

    typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT} icache_state_t;

    typedef struct packed {
        logic                       valid;
        logic [ICACHE_TAG_BITS-1:0] tag;
        logic [LINE_BITS-1:0]       data;
    } icache_line_t;

    function automatic logic [ICACHE_IDX_BITS-1:0] line_idx(input logic [ADDR_W-1:0] a);
        return a[ICACHE_OFF_BITS +: ICACHE_IDX_BITS];
    endfunction

    function automatic logic [ICACHE_TAG_BITS-1:0] line_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: ICACHE_TAG_BITS];
    endfunction
endpackage

// File: rtl/icache_array.sv
// icache_array: direct-mapped valid/tag/data storage, one async read port, one write port, flush-all
// Ports: clock, reset (async, clears valid bits only); rd_idx -> rd_line (combinational);
//        wr_en/wr_idx/wr_tag/wr_data install a line; flush_all clears every valid bit.
module icache_array
    import icache_responder_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ICACHE_IDX_BITS-1:0] rd_idx,
    output icache_line_t               rd_line,
    input  logic                       wr_en,
    input  logic [ICACHE_IDX_BITS-1:0] wr_idx,
    input  logic [ICACHE_TAG_BITS-1:0] wr_tag,
    input  logic [LINE_BITS-1:0]       wr_data,
    input  logic                       flush_all
);
    logic [NUM_LINES-1:0]       valid;
    logic [ICACHE_TAG_BITS-1:0] tags [NUM_LINES];
    logic [LINE_BITS-1:0]       lines [NUM_LINES];

    always_ff @(posedge clock or posedge reset)
        if (reset)
            valid <= '0;
        else if (flush_all)
            valid <= '0;
        else if (wr_en)
            valid[wr_idx] <= 1'b1;

    // tag and data storage is deliberately left unreset
    always_ff @(posedge clock)
        if (wr_en) begin
            tags[wr_idx]  <= wr_tag;
            lines[wr_idx] <= wr_data;
        end

    assign rd_line = {valid[rd_idx], tags[rd_idx], lines[rd_idx]};
endmodule

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped I-cache answering fetch lookups and refilling misses from memory
// Ports: clock, reset (async active-high); proc2Icache_addr in, Icache2proc_data/_valid out (1-cycle hit);
//        flush invalidates all lines; Icache2mem_req_valid/Icache2mem_addr + mem2Icache_req_ready form the
//        refill request; mem2Icache_data/_valid return the refill line.
// Optional: define ICACHE_PERF_CNT_EN to add perf_hits / perf_misses counters.
module icache_responder
    import icache_responder_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    proc2Icache_addr,
    output logic [LINE_BITS-1:0] Icache2proc_data,
    output logic                 Icache2proc_data_valid,
    input  logic                 flush,
`ifdef ICACHE_PERF_CNT_EN
    output logic [31:0]          perf_hits,
    output logic [31:0]          perf_misses,
`endif
    output logic                 Icache2mem_req_valid,
    output logic [ADDR_W-1:0]    Icache2mem_addr,
    input  logic                 mem2Icache_req_ready,
    input  logic [LINE_BITS-1:0] mem2Icache_data,
    input  logic                 mem2Icache_data_valid
);
    icache_state_t state, state_n;
    icache_line_t  lookup;
    logic          flush_pending, hit, idle_hit, miss, install;

    assign hit      = lookup.valid && lookup.tag == line_tag(proc2Icache_addr);
    assign idle_hit = state == IDLE && !flush && hit;
    assign miss     = state == IDLE && !flush && !hit;
    // a flush seen at any point of the miss (or with the response) drops the refill
    assign install  = state == MISS_WAIT && mem2Icache_data_valid && !flush && !flush_pending;

    icache_array u_array (
        .clock     (clock),
        .reset     (reset),
        .rd_idx    (line_idx(proc2Icache_addr)),
        .rd_line   (lookup),
        .wr_en     (install),
        .wr_idx    (line_idx(Icache2mem_addr)),
        .wr_tag    (line_tag(Icache2mem_addr)),
        .wr_data   (mem2Icache_data),
        .flush_all (flush)
    );

    always_ff @(posedge clock or posedge reset)
        if (reset)
            state <= IDLE;
        else
            state <= state_n;

    always_comb
        state_n = state == IDLE     ? (miss ? MISS_REQ : IDLE) :
                  state == MISS_REQ ? (mem2Icache_req_ready ? MISS_WAIT : MISS_REQ) :
                                      (mem2Icache_data_valid ? IDLE : MISS_WAIT);

    always_comb
        Icache2mem_req_valid = state == MISS_REQ;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            Icache2proc_data       <= '0;
            Icache2proc_data_valid <= 1'b0;
            Icache2mem_addr        <= '0;
            flush_pending          <= 1'b0;
        end else begin
            Icache2proc_data_valid <= idle_hit;
            if (idle_hit)
                Icache2proc_data <= lookup.data;
            if (miss)
                Icache2mem_addr <= {proc2Icache_addr[ADDR_W-1:ICACHE_OFF_BITS], {ICACHE_OFF_BITS{1'b0}}};
            flush_pending <= state_n == IDLE ? 1'b0 : flush_pending | (flush && state != IDLE);
        end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else begin
            perf_hits   <= perf_hits + {31'd0, idle_hit};
            perf_misses <= perf_misses + {31'd0, miss};
        end
`endif
endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-cache responder: the far end of the fetch stage's proc2Icache_addr / Icache2proc_data / Icache2proc_data_valid interface.
- Direct-mapped; one line equals one fetch pack (`INST_PACK bits).
- Hits return a full pack; misses refill the line from the memory side with one outstanding request.
- Sits between the fetch stage and the L2/memory port; owns tag/valid/data arrays and the refill FSM.

Parameters:
- NUM_LINES, 64, number of direct-mapped lines (power of 2).
- LINE_BITS, `INST_PACK, line/pack width in bits (128 = 4 x 32-bit insts).
- ADDR_W, `INST_WIDTH, address width (32).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- proc2Icache_addr  in  ADDR_W  fetch address; held by fetch while stalled
- Icache2proc_data  out  LINE_BITS  aligned line containing the sampled address
- Icache2proc_data_valid  out  1  data valid, one cycle per hit lookup
- flush  in  1  invalidate all lines (fence.i)
- Icache2mem_req_valid  out  1  refill request valid
- Icache2mem_addr  out  ADDR_W  line-aligned refill address
- mem2Icache_req_ready  in  1  memory accepts request
- mem2Icache_data  in  LINE_BITS  refill line
- mem2Icache_data_valid  in  1  refill data valid; one-cycle pulse, in order

Behaviour:
- Address split: OFF = log2(LINE_BITS/8) (4); IDX = log2(NUM_LINES); tag = addr[ADDR_W-1:OFF+IDX].
- The cache returns the whole aligned line; the fetch side selects the slot.
- Reset (async):
  - all valid bits cleared; state IDLE.
  - Icache2proc_data = 0, Icache2proc_data_valid = 0, Icache2mem_req_valid = 0, Icache2mem_addr = 0.
  - Tag and data arrays are not reset.
- FSM states: IDLE, MISS_REQ, MISS_WAIT.
- IDLE, each cycle: look up proc2Icache_addr.
  - Hit: at the next posedge, Icache2proc_data <= line and valid <= 1. Hit latency is 1 cycle; full throughput of one pack per cycle.
  - Miss: valid <= 0; capture line address (addr with OFF bits zeroed) into Icache2mem_addr; go to MISS_REQ.
- MISS_REQ:
  - Icache2mem_req_valid = 1; address held stable.
  - When mem2Icache_req_ready = 1 at a posedge, deassert req_valid and go to MISS_WAIT.
- MISS_WAIT: on mem2Icache_data_valid, write data, tag and valid for the captured index, then go to IDLE.
  - Refill data is not forwarded.
  - The next IDLE lookup hits, so miss-to-data latency = (accept-to-response cycles) + 3.
- Icache2proc_data_valid = 0 throughout MISS_REQ and MISS_WAIT; Icache2proc_data keeps its last value.
- Redirect mid-miss (address changes during MISS_*): the refill for the captured address still completes and is installed. The IDLE lookup then uses the current address.
- Conflict: a refill overwrites the resident line at that index unconditionally.
- Flush:
  - In IDLE: all valid bits cleared at the posedge and valid <= 0; the lookup in that cycle is treated as a miss-free no-op (no request issued).
  - In MISS_REQ or MISS_WAIT: set flush_pending and clear all valid bits. The in-flight request still completes handshake and response, but the response is dropped (no install). Return to IDLE and clear flush_pending.
- Simultaneous flush and refill response in MISS_WAIT: the response is dropped.
- Reset mid-miss: FSM returns to IDLE. Any later stale mem2Icache_data_valid while in IDLE is ignored.
- At most one outstanding memory request; no second request until the response is received.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- Defined: adds outputs perf_hits and perf_misses (32 bits each, wrap on overflow).
  - Reset to 0; flush does not clear them.
  - perf_hits increments on each IDLE hit; perf_misses increments on each IDLE miss transition.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (micro_op.svh family): ICACHE_OFF_BITS and ICACHE_IDX_BITS constants; icache_state_t enum (IDLE, MISS_REQ, MISS_WAIT); icache_line_t struct {valid, tag, data}.
- One natural sub-module: icache_array. It holds the data/tag/valid storage, with single read and write ports and a flush-all input.
- The FSM and interface logic stay in icache_responder.

Test Plan:
- Cold miss: reset, addr 0x0000_1004, memory ready immediately, response 2 cycles later with 0xDEAD...0001 → one request at 0x0000_1000, then valid=1 with that line at the expected latency.
- Hit streaming: after the fill, hold addr 0x1004 then step 0x1010, 0x1000 (filled) → valid=1 every cycle for 0x1004/0x1000; miss request for 0x1010.
- Conflict: fill 0x1000, then 0x1400 (same index, NUM_LINES=64) → 0x1400 refilled; re-accessing 0x1000 misses again.
- Backpressure: mem2Icache_req_ready low for 5 cycles → req_valid and Icache2mem_addr stable for all 5 cycles; exactly one request accepted.
- Flush mid-miss: flush asserted in MISS_WAIT one cycle before the response → line not installed; re-lookup of the same addr issues a new request.
- Redirect mid-miss: addr changes 0x2000→0x3000 during MISS_WAIT → 0x2000 installed, then a miss request issued for 0x3000.
